// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode map, controller states and
// the width helper for the iteration counter.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_MOD = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_XOR = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  // Bits needed to hold an iteration count from 0 to width inclusive.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/alu_seq_divmul.sv
// Iterative shift-add multiplier / restoring divider sharing one
// accumulator, one shift register and one iteration counter.
module alu_seq_divmul
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             hi_nonzero
);

  localparam int unsigned CW = cnt_width(WIDTH);

  alu_op_t          op_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] dv;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] acc_n;
  logic [WIDTH-1:0] sh_n;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   rem;

  // One iteration: {acc,sh} is the product (MUL) or remainder:dividend (DIV/MOD).
  always_comb begin
    acc_n = acc;
    sh_n  = sh;
    sum   = '0;
    trial = '0;
    rem   = '0;
    if (op_q == OP_MUL) begin
      sum   = {1'b0, acc} + (sh[0] ? {1'b0, dv} : '0);
      acc_n = sum[WIDTH:1];
      sh_n  = {sum[0], sh[WIDTH-1:1]};
    end else begin
      trial = {acc, sh[WIDTH-1]};
      if (trial >= {1'b0, dv}) begin
        rem  = trial - {1'b0, dv};
        sh_n = {sh[WIDTH-2:0], 1'b1};
      end else begin
        rem  = trial;
        sh_n = {sh[WIDTH-2:0], 1'b0};
      end
      acc_n = rem[WIDTH-1:0];
    end
  end

  // The final iteration is presented combinationally so the controller
  // can capture it on the same edge the counter reaches zero.
  assign done       = (cnt == CW'(1));
  assign result     = (op_q == OP_MOD) ? acc_n : sh_n;
  assign hi_nonzero = (op_q == OP_MUL) && (acc_n != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= OP_ADD;
      acc  <= '0;
      sh   <= '0;
      dv   <= '0;
      cnt  <= '0;
    end else if (start) begin
      op_q <= op;
      acc  <= '0;
      sh   <= a;
      dv   <= b;
      cnt  <= CW'(WIDTH);
    end else if (cnt != '0) begin
      acc  <= acc_n;
      sh   <= sh_n;
      cnt  <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready on both sides: single-cycle
// logic/arith/shift ops plus an iterative engine for MUL/DIV/MOD.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       S,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Q,
  output logic             N,
  output logic             Z,
  output logic             V,
  output logic             C
);

  alu_state_t         state;
  alu_state_t         state_nxt;
  alu_op_t            op;
  logic               start;
  logic               load;
  logic [WIDTH-1:0]   ld_q;
  logic               ld_v;
  logic               ld_c;
  logic [WIDTH-1:0]   sc_q;
  logic               sc_v;
  logic               sc_c;
  logic [WIDTH:0]     ext;
  logic [2*WIDTH-1:0] wide;
  logic               eng_done;
  logic               eng_hi;
  logic [WIDTH-1:0]   eng_result;

  assign op    = alu_op_t'(S);
  assign start = (state == IDLE) && in_valid &&
                 ((op == OP_MUL) || (((op == OP_DIV) || (op == OP_MOD)) && (B != '0)));

  alu_seq_divmul #(.WIDTH(WIDTH)) u_divmul (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .a          (A),
    .b          (B),
    .done       (eng_done),
    .result     (eng_result),
    .hi_nonzero (eng_hi)
  );

  // Single-cycle datapath; DIV/MOD entries here only cover divide-by-zero.
  always_comb begin
    sc_q = '0;
    sc_v = 1'b0;
    sc_c = 1'b0;
    ext  = '0;
    wide = '0;
    case (op)
      OP_ADD: begin
        ext  = {1'b0, A} + {1'b0, B};
        sc_q = ext[WIDTH-1:0];
        sc_c = ext[WIDTH];
        sc_v = (A[WIDTH-1] == B[WIDTH-1]) && (sc_q[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        ext  = {1'b0, A} - {1'b0, B};
        sc_q = ext[WIDTH-1:0];
        sc_c = ~ext[WIDTH];
        sc_v = (A[WIDTH-1] != B[WIDTH-1]) && (sc_q[WIDTH-1] != A[WIDTH-1]);
      end
      OP_DIV: begin
        sc_q = '1;
        sc_v = 1'b1;
      end
      OP_MOD: begin
        sc_q = A;
        sc_v = 1'b1;
      end
      OP_AND: sc_q = A & B;
      OP_OR:  sc_q = A | B;
      OP_XOR: sc_q = A ^ B;
      // The bit just past the result window is the last one shifted out.
      OP_SHL: begin
        wide = {{WIDTH{1'b0}}, A} << B;
        sc_q = wide[WIDTH-1:0];
        sc_c = wide[WIDTH];
      end
      OP_SHR: begin
        wide = {A, {WIDTH{1'b0}}} >> B;
        sc_q = wide[2*WIDTH-1:WIDTH];
        sc_c = wide[WIDTH-1];
      end
      OP_MUL: sc_q = '0;
      default: sc_v = 1'b1;
    endcase
  end

  // Next-state and result-load selection.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    ld_q      = sc_q;
    ld_v      = sc_v;
    ld_c      = sc_c;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (start) begin
            state_nxt = BUSY;
          end else begin
            state_nxt = DONE;
            load      = 1'b1;
          end
        end
      end
      BUSY: begin
        if (eng_done) begin
          state_nxt = DONE;
          load      = 1'b1;
          ld_q      = eng_result;
          ld_v      = eng_hi;
          ld_c      = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      Q         <= '0;
      N         <= 1'b0;
      Z         <= 1'b0;
      V         <= 1'b0;
      C         <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt == DONE);
      in_ready  <= (state_nxt == IDLE);
      if (load) begin
        Q <= ld_q;
        N <= ld_q[WIDTH-1];
        Z <= (ld_q == '0);
        V <= ld_v;
        C <= ld_c;
      end
    end
  end

endmodule
